reg_bank_scanner: RTL and testbench
===================================

# reg_bank_scanner

Read-side initiator for the 8×16-bit register bank. On a start pulse it walks a range of bank addresses by driving the bank's read select, and captures each combinational read word. It then emits each word on a valid/ready stream toward the debug/trace path. It never writes the bank; it shares the bank's read port with no other master while busy.

## Interface
- DATA_W, 16, width of bank word and stream data
- SEL_W, 3, width of bank address (bank depth = 2^SEL_W = 8)
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request a scan; sampled only in IDLE
- first_sel  input  SEL_W  first address of scan, latched with start
- last_sel  input  SEL_W  last address of scan, latched with start
- read_sel  output  SEL_W  address driven to bank read port
- rb_data_out  input  DATA_W  combinational read data from bank
- out_data  output  DATA_W  stream word
- out_idx  output  SEL_W  bank address of out_data (0 on checksum beat)
- out_valid  output  1  stream word valid
- out_ready  input  1  downstream accepts word
- out_last  output  1  marks final beat of scan
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse at scan completion

## Operation
- Reset (rst=0, any time, including mid-scan): state IDLE; read_sel, out_data, out_idx, cur, last, checksum = 0; out_valid, out_last, busy, done = 0. Any beat in flight is dropped.
- States: IDLE, READ, SEND, CHK (macro only), DONE.
- IDLE: if start=1, latch cur=first_sel, last=last_sel, clear checksum, go READ. Otherwise hold.
- READ: read_sel=cur. At the edge: out_data<=rb_data_out, out_idx<=cur, out_valid<=1, and out_last<=(cur==last && no checksum). Go SEND.
- SEND: hold out_data/out_idx/out_last stable while out_ready=0. On out_valid&&out_ready edge: clear out_valid and add word to checksum. Then:
  - if cur==last: go CHK (macro) or DONE;
  - else cur<=cur+1 (mod 2^SEL_W), go READ.
- Range wraps: last_sel<first_sel scans first..7,0..last (e.g. 6→1 = 6,7,0,1). first_sel==last_sel scans exactly one register. A scan is never empty; max 8 words.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- start is ignored in READ/SEND/CHK/DONE; start in the cycle after DONE begins a new scan.
- Bank writes during a scan: each word reflects bank content at its READ edge; later writes are not re-sampled.
- read_sel holds its last driven value outside READ.

## Timing
- start sampled at edge N → READ in cycle N+1 (read_sel=first) → out_valid=1 after edge N+2.
- With out_ready tied high: one word per 2 cycles. A scan of K registers reaches DONE 2K+1 cycles after the start edge, +2 with checksum beat.
- done asserts in the cycle after the final handshake; busy falls with done's deassertion.
- Outputs are all registered except busy (decoded from state register).

## Configuration
- REG_SCAN_CHECKSUM_EN defined: after the last register handshake, state CHK emits one extra beat. That beat carries out_data = 16-bit wrapping sum of all emitted words, out_idx=0 and out_last=1, under the same valid/ready rules, then DONE. out_last is 0 on register beats.
- Undefined: CHK state and checksum register absent; out_last=1 on the final register beat.

## Test plan
- Reset mid-SEND with out_ready=0: rst low → out_valid=0, busy=0, read_sel=0 immediately; after release, a start scans normally.
- Bank 0..7 = 0x1000+i, scan 0→7, out_ready=1: eight beats 0x1000..0x1007, out_idx 0..7, one beat per 2 cycles, out_last on idx 7 (no macro), done 17 cycles after start.
- Wrap scan 6→1: beats idx 6,7,0,1 in order; out_last only on idx 1.
- Backpressure: out_ready=0 for 5 cycles on beat 2; out_data/out_idx remain stable; no beat lost or duplicated; start pulsed while busy is ignored.
- first_sel=last_sel=3, bank[3]=0xBEEF: single beat 0xBEEF with out_last=1 (no macro), done pulse one cycle later.
- With REG_SCAN_CHECKSUM_EN, scan 0→1 of 0xFFFF, 0x0002: beats 0xFFFF, 0x0002, then checksum 0x0001 with out_idx=0 and out_last=1.

Source files
------------

// File: rtl/reg_bank_scanner.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_scanner
// Brief    : Walks a bank address range, streams each read word over valid/ready.
//            Optional trailing checksum beat under REG_SCAN_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_scanner #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  first_sel,
  input  logic [SEL_W-1:0]  last_sel,
  output logic [SEL_W-1:0]  read_sel,
  input  logic [DATA_W-1:0] rb_data_out,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_SEND = 3'd2,
`ifdef REG_SCAN_CHECKSUM_EN
    S_CHK  = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [SEL_W-1:0]   r_cur;
  logic [SEL_W-1:0]   r_last;
  logic [DATA_W-1:0]  r_out_data;
  logic [SEL_W-1:0]   r_out_idx;
  logic               r_out_valid;
  logic               r_out_last;
  logic               r_done;
  logic               w_hs;
  logic               w_at_last;
`ifdef REG_SCAN_CHECKSUM_EN
  logic [DATA_W-1:0]  r_checksum;
`endif

  assign w_hs      = r_out_valid & out_ready;
  assign w_at_last = (r_cur == r_last);

  // cur only changes on the way into READ, so it doubles as the read select
  assign read_sel  = r_cur;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_READ;
        end
      end
      S_READ: begin
        w_state_next = S_SEND;
      end
      S_SEND: begin
        if (w_hs) begin
          if (w_at_last) begin
`ifdef REG_SCAN_CHECKSUM_EN
            w_state_next = S_CHK;
`else
            w_state_next = S_DONE;
`endif
          end else begin
            w_state_next = S_READ;
          end
        end
      end
`ifdef REG_SCAN_CHECKSUM_EN
      S_CHK: begin
        if (w_hs) begin
          w_state_next = S_DONE;
        end
      end
`endif
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur       <= '0;
      r_last      <= '0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
`ifdef REG_SCAN_CHECKSUM_EN
      r_checksum  <= '0;
`endif
    end else begin
      // DONE always falls straight back to IDLE, so this is a single-cycle pulse
      r_done <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur  <= first_sel;
            r_last <= last_sel;
`ifdef REG_SCAN_CHECKSUM_EN
            r_checksum <= '0;
`endif
          end
        end
        S_READ: begin
          r_out_data  <= rb_data_out;
          r_out_idx   <= r_cur;
          r_out_valid <= 1'b1;
`ifdef REG_SCAN_CHECKSUM_EN
          r_out_last  <= 1'b0;
`else
          r_out_last  <= w_at_last;
`endif
        end
        S_SEND: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
`ifdef REG_SCAN_CHECKSUM_EN
            r_checksum  <= r_checksum + r_out_data;
`endif
            if (!w_at_last) begin
              r_cur <= r_cur + SEL_W'(1);
            end
          end
        end
`ifdef REG_SCAN_CHECKSUM_EN
        S_CHK: begin
          // first cycle loads the checksum beat, then wait for its handshake
          if (!r_out_valid) begin
            r_out_data  <= r_checksum;
            r_out_idx   <= '0;
            r_out_last  <= 1'b1;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for reg_bank_scanner: expected beats queued per scan,
// popped by a negedge monitor on each valid/ready handshake.
module tb_reg_bank_scanner;
  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;
`ifdef REG_SCAN_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              out_ready = 1'b1;
  logic [SEL_W-1:0]  first_sel = '0;
  logic [SEL_W-1:0]  last_sel = '0;
  logic [SEL_W-1:0]  read_sel;
  logic [SEL_W-1:0]  out_idx;
  logic [DATA_W-1:0] rb_data_out;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] bank [8];
  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  idx;
    logic              last;
  } beat_t;
  beat_t exp_q [$];

  always #5 clk = ~clk;
  assign rb_data_out = bank[read_sel];

  reg_bank_scanner #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .first_sel(first_sel), .last_sel(last_sel),
    .read_sel(read_sel), .rb_data_out(rb_data_out), .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_unexpected: got data=%0h idx=%0d last=%0b expected none", out_data, out_idx, out_last);
      end else begin
        e = exp_q.pop_front();
        check("beat{data,idx,last}", 32'({out_data, out_idx, out_last}), 32'(e));
      end
    end
  end

  function automatic int push_scan(input int f, input int l);
    int a = f;
    int k = 0;
    logic [DATA_W-1:0] sum = '0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{data: bank[a], idx: SEL_W'(a), last: (a == l) && !CK});
      sum += bank[a];
      k++;
      if (a == l) break;
      a = (a + 1) % 8;
    end
    if (CK) exp_q.push_back('{data: sum, idx: '0, last: 1'b1});
    return k;
  endfunction

  // stall_idx >= 0 holds out_ready low for 5 cycles on that beat and pokes start meanwhile
  task automatic run_scan(input int f, input int l, input int stall_idx);
    int k, n, stalls, exp_n;
    k = push_scan(f, l);
    @(posedge clk); #1;
    first_sel = SEL_W'(f);
    last_sel  = SEL_W'(l);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    n      = 0;
    stalls = 0;
    while (!done && n < 100) begin
      if (stall_idx >= 0 && out_valid && int'(out_idx) == stall_idx && stalls < 5) begin
        out_ready = 1'b0;
        start     = 1'b1;
        first_sel = '0;
        last_sel  = '0;
        stalls++;
        check("stall_data", 32'(out_data), 32'(bank[stall_idx]));
        check("stall_idx", 32'(out_idx), 32'(stall_idx));
      end else begin
        out_ready = 1'b1;
        start     = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    // edges after the start-sampling edge; counting the start cycle this is 2K+1
    exp_n = 2 * k + (CK ? 2 : 0) + ((stall_idx >= 0) ? 5 : 0);
    check("done_latency", 32'(n), 32'(exp_n));
    check("busy_at_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("done_pulse_end", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) bank[i] = 16'h1000 + 16'(i);

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_read_sel", 32'(read_sel), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    rst = 1'b1;

    // reset asserted mid-SEND while stalled
    @(posedge clk); #1;
    first_sel = 3'd5;
    last_sel  = 3'd7;
    start     = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_read_sel", 32'(read_sel), 32'd5);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_read_sel", 32'(read_sel), 32'd0);
    check("midrst_out_idx", 32'(out_idx), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;

    run_scan(0, 7, -1);
    run_scan(6, 1, -1);
    run_scan(0, 4, 2);
    bank[3] = 16'hBEEF;
    run_scan(3, 3, -1);
    bank[0] = 16'hFFFF;
    bank[1] = 16'h0002;
    run_scan(0, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
